// File: rtl/axi_imem_rd_slave_pkg.sv
// ---------------------------------------------------------------------------
// axi_imem_pkg
// Shared definitions for the instruction-memory AXI read responder:
//   - AXI burst type and response codes
//   - responder state enum
//   - next_addr(): address of the following beat for FIXED/INCR/WRAP bursts
// ---------------------------------------------------------------------------
package axi_imem_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DATA
  } state_t;

  // WRAP only wraps for 2/4/8/16-beat bursts. The wrap window is
  // (len+1)*4 bytes, so the mask covers the byte offset inside that window;
  // any other WRAP length falls back to plain incrementing.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [1:0]  burst,
                                            input logic [7:0]  len);
    logic [31:0] mask;
    logic [31:0] res;
    mask = ({24'h0, len} << 2) | 32'h3;
    res  = addr + 32'd4;
    if (burst == BURST_FIXED) begin
      res = addr;
    end else if (burst == BURST_WRAP &&
                 (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
      res = (addr & ~mask) | ((addr + 32'd4) & mask);
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_imem_rd_slave_if.sv
// ---------------------------------------------------------------------------
// axi_imem_rd_slave_if
// AXI4 read-address and read-data channels between the I-cache refill master
// and the instruction-memory responder.
//   AR: arvalid, araddr[31:0], arid[ID_W-1:0], arlen[7:0], arburst[1:0], arready
//   R : rvalid, rdata[31:0], rresp[1:0], rid[ID_W-1:0], rlast, rready
// Modports: master (refill side), slave (memory side).
// ---------------------------------------------------------------------------
interface axi_imem_rd_slave_if #(
  parameter int ID_W = 4
) ();

  logic            arvalid;
  logic [31:0]     araddr;
  logic [ID_W-1:0] arid;
  logic [7:0]      arlen;
  logic [1:0]      arburst;
  logic            arready;

  logic            rvalid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic [ID_W-1:0] rid;
  logic            rlast;
  logic            rready;

  modport master (
    output arvalid, araddr, arid, arlen, arburst, rready,
    input  arready, rvalid, rdata, rresp, rid, rlast
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arburst, rready,
    output arready, rvalid, rdata, rresp, rid, rlast
  );

endinterface

// File: rtl/axi_imem_rd_slave_sram.sv
// ---------------------------------------------------------------------------
// imem_sram_1rw
// Single-port synchronous RAM, DEPTH x 32. One access per cycle: a write
// takes the port, otherwise the addressed word appears on rdata after the
// clock edge. Contents and output register are not reset.
//   clk   in   clock
//   we    in   write enable (has priority over the read)
//   addr  in   word address
//   wdata in   write data
//   rdata out  registered read data
// ---------------------------------------------------------------------------
module imem_sram_1rw #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/axi_imem_rd_slave.sv
// ---------------------------------------------------------------------------
// axi_imem_rd_slave
// AXI4 read-only responder in front of the instruction RAM. Serves
// FIXED/INCR/WRAP bursts of 32-bit beats, flags out-of-range beats and
// reserved bursts with SLVERR, and keeps one extra AR in a skid slot so the
// next burst starts right after the current rlast. The RAM is preloaded
// through the init_* port while the responder is idle.
// Ports:
//   clk_i        clock
//   rst_i        asynchronous reset, active-low
//   axi          AXI AR/R channels (slave modport)
//   init_we_i    preload write strobe
//   init_addr_i  preload byte address
//   init_data_i  preload word
//   init_drop_o  sticky flag: a preload write was discarded
// ---------------------------------------------------------------------------
module axi_imem_rd_slave
  import axi_imem_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
  parameter int          ID_W      = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  axi_imem_rd_slave_if.slave  axi,
  input  logic                init_we_i,
  input  logic [31:0]         init_addr_i,
  input  logic [31:0]         init_data_i,
  output logic                init_drop_o
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);

  // BASE_ADDR and the window size are word aligned, so comparing the full
  // byte address gives the same answer as comparing its word address.
  function automatic logic in_range(input logic [31:0] a);
    return (a >= BASE_ADDR) && ({1'b0, a} < END_ADDR);
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  state_t          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [7:0]      len_q, len_d;
  logic [1:0]      burst_q, burst_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [7:0]      beat_q, beat_d;

  logic            pend_valid_q, pend_valid_d;
  logic [31:0]     pend_addr_q, pend_addr_d;
  logic [7:0]      pend_len_q, pend_len_d;
  logic [1:0]      pend_burst_q, pend_burst_d;
  logic [ID_W-1:0] pend_id_q, pend_id_d;

  logic            drop_q;

  logic            ar_ready, ar_hs, r_hs, beat_last, burst_done;
  logic            init_ok, beat_err, in_data;
  logic [31:0]     ram_byte_addr, ram_rdata;

  // Handshake qualifiers. arready is held low during reset and while a
  // preload write is offered, so a write always wins over a new AR.
  always_comb begin
    ar_ready   = rst_i && !init_we_i && (state_q == ST_IDLE || !pend_valid_q);
    ar_hs      = axi.arvalid && ar_ready;
    in_data    = (state_q == ST_DATA);
    r_hs       = in_data && axi.rready;
    beat_last  = (beat_q == len_q);
    burst_done = r_hs && beat_last;
    init_ok    = init_we_i && (state_q == ST_IDLE) && in_range(init_addr_i);
    beat_err   = (burst_q == BURST_RSVD) || !in_range(addr_q);
  end

  // Burst sequencing: the active burst advances one beat per R handshake;
  // an AR seen while busy parks in the skid slot and is launched straight
  // into FETCH on the final handshake of the active burst.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    burst_d      = burst_q;
    id_d         = id_q;
    beat_d       = beat_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_len_d   = pend_len_q;
    pend_burst_d = pend_burst_q;
    pend_id_d    = pend_id_q;

    case (state_q)
      ST_IDLE: begin
        if (ar_hs) begin
          addr_d  = axi.araddr;
          len_d   = axi.arlen;
          burst_d = axi.arburst;
          id_d    = axi.arid;
          beat_d  = 8'd0;
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        state_d = ST_DATA;
        if (ar_hs) begin
          pend_valid_d = 1'b1;
          pend_addr_d  = axi.araddr;
          pend_len_d   = axi.arlen;
          pend_burst_d = axi.arburst;
          pend_id_d    = axi.arid;
        end
      end

      ST_DATA: begin
        if (burst_done) begin
          beat_d = 8'd0;
          if (pend_valid_q) begin
            addr_d       = pend_addr_q;
            len_d        = pend_len_q;
            burst_d      = pend_burst_q;
            id_d         = pend_id_q;
            pend_valid_d = 1'b0;
            state_d      = ST_FETCH;
          end else if (ar_hs) begin
            addr_d  = axi.araddr;
            len_d   = axi.arlen;
            burst_d = axi.arburst;
            id_d    = axi.arid;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          if (r_hs) begin
            addr_d = next_addr(addr_q, burst_q, len_q);
            beat_d = beat_q + 8'd1;
          end
          if (ar_hs) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = axi.araddr;
            pend_len_d   = axi.arlen;
            pend_burst_d = axi.arburst;
            pend_id_d    = axi.arid;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      burst_q      <= '0;
      id_q         <= '0;
      beat_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_len_q   <= '0;
      pend_burst_q <= '0;
      pend_id_q    <= '0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      burst_q      <= burst_d;
      id_q         <= id_d;
      beat_q       <= beat_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_len_q   <= pend_len_d;
      pend_burst_q <= pend_burst_d;
      pend_id_q    <= pend_id_d;
      drop_q       <= drop_q | (init_we_i && !init_ok);
    end
  end

  // The RAM always reads the address the beat register will hold next, so
  // during a stall it re-reads the same word and rdata stays put, and on a
  // handshake the following word is already on its way.
  assign ram_byte_addr = init_ok ? init_addr_i : addr_d;

  imem_sram_1rw #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_sram (
    .clk   (clk_i),
    .we    (init_ok),
    .addr  (word_idx(ram_byte_addr)),
    .wdata (init_data_i),
    .rdata (ram_rdata)
  );

  assign axi.arready = ar_ready;
  assign axi.rvalid  = in_data;
  assign axi.rlast   = in_data && beat_last;
  assign axi.rresp   = (in_data && beat_err) ? RESP_SLVERR : RESP_OKAY;
  assign axi.rdata   = (in_data && !beat_err) ? ram_rdata : 32'h0;
  assign axi.rid     = in_data ? id_q : '0;
  assign init_drop_o = drop_q;

endmodule
